capture_scan_ctrl: RTL and testbench
====================================

// Module: capture_scan_ctrl
// PURPOSE
//  Sequences vessel-vs-planet capture (overlap) checks across all planets.
//  Uses one shared squarer instead of per-planet parallel squared-distance logic.
//  Sits between the planet position/size table and the orbit state machine.
//  Reports the lowest-index planet whose disc overlaps the vessel disc.
// PARAMETERS
//  NUM_PLANETS  8   planets scanned per request (index 0..NUM_PLANETS-1)
//  COORD_W      12  signed width of X/Y coordinates (pixels)
//  SIZE_W       8   unsigned width of radii (planet and vessel)
// PORTS
//  frame_clk   in   1                  clock
//  Reset       in   1                  asynchronous, active-high reset
//  scan_start  in   1                  request a scan; accepted only in IDLE
//  vessel_x    in   COORD_W            vessel centre X, signed
//  vessel_y    in   COORD_W            vessel centre Y, signed
//  vessel_s    in   SIZE_W             vessel radius
//  plan_sel    out  $clog2(NUM_PLANETS) planet index presented to the planet table
//  plan_x      in   COORD_W            X of planet plan_sel (combinational table read)
//  plan_y      in   COORD_W            Y of planet plan_sel
//  plan_s      in   SIZE_W             radius of planet plan_sel
//  busy        out  1                  high from the cycle after start acceptance until done
//  done        out  1                  one-cycle pulse; scan result valid this cycle
//  hit         out  1                  overlap found; held until next acceptance
//  hit_idx     out  $clog2(NUM_PLANETS) captured planet; all-ones when hit=0
// BEHAVIOUR
//  Reset values: busy=0, done=0, hit=0, hit_idx=all-ones, plan_sel=0, state=IDLE.
//  Reset mid-scan: scan aborts immediately; no done pulse is produced.
//  State flow: IDLE -> FETCH -> SQX -> SQY -> SQR -> (FETCH | DONE) -> IDLE.
//  Per-planet state actions:
//   IDLE   scan_start=1: latch vessel_x/y/s, clear hit, set plan_sel=0, go to FETCH.
//   FETCH  register plan_x/y/s for plan_sel. Later table changes do not affect this planet.
//   SQX    acc <= (plan_x - vessel_x)^2.
//   SQY    acc <= acc + (plan_y - vessel_y)^2.
//   SQR    compare acc <= (plan_s + vessel_s)^2. Boundary equality counts as a hit.
//          On hit: hit<=1, hit_idx<=plan_sel, go to DONE (early exit).
//          Else if plan_sel==NUM_PLANETS-1: go to DONE with hit=0.
//          Else: plan_sel++ and go to FETCH.
//   DONE   done=1 for exactly one cycle, busy=0, return to IDLE.
//  Handshake and latency:
//   scan_start while busy, or in the DONE cycle, is ignored (not queued).
//   scan_start held high re-triggers a new scan each time the block is in IDLE.
//   Latency: start accepted at cycle 0, hit at planet k gives done at cycle 4k+5.
//   Latency with no hit: done at cycle 4*NUM_PLANETS+1 (33 for the default).
//  Arithmetic:
//   Differences are signed, COORD_W+1 bits. Squares are 2*(COORD_W+1) bits, unsigned.
//   acc is 2*(COORD_W+1)+1 bits, so there is no overflow or wrap.
//   Radius sum is SIZE_W+1 bits; its square is zero-extended to the acc width.
//  Priority: lowest index wins, matching the existing orbit capture order.
//  hit/hit_idx keep the last result until the next accepted scan_start.
// STRUCTURE
//  Shared package orbit_pkg:
//   coord_t, size_t, plan_idx_t typedefs
//   scan_state_t enum
//   NO_PLANET constant (all-ones index)
//   NUM_PLANETS default
//  Sub-module sq_unit: one combinational signed squarer, (COORD_W+1) in -> 2*(COORD_W+1) out.
//  The FSM muxes dx, dy or the radius sum into sq_unit each cycle.
//  The operand mux, acc register and FSM stay in this module.
// TESTING
//  1) Vessel (0,0) s=4; planet3 at (10,0) s=6 (dist^2=100=(10)^2); others far
//     -> done at cycle 17, hit=1, hit_idx=3.
//  2) All planets at (500,500) s=1, vessel (0,0) s=1
//     -> done at cycle 33, hit=0, hit_idx=7, busy high cycles 1..32.
//  3) Planets 2 and 5 both overlap the vessel -> hit_idx=2, done at cycle 13.
//  4) Negative coords: vessel (-100,-50) s=2, planet0 (-103,-54) s=3 (25<=25)
//     -> hit=1, hit_idx=0, done at cycle 5.
//  5) Pulse scan_start at cycles 3 and 17 of a no-hit scan -> both ignored.
//     Exactly one done pulse; start at cycle 34 is accepted.
//  6) Assert Reset at cycle 10 mid-scan -> all outputs at reset values next edge.
//     No done pulse; a fresh scan afterwards yields correct timing.

Source files
------------

// File: rtl/orbit_pkg.sv
// orbit_pkg: shared types and sizing for the orbit capture logic.
package orbit_pkg;
  localparam int NUM_PLANETS = 8;
  localparam int COORD_W = 12;
  localparam int SIZE_W = 8;
  localparam int IDX_W = $clog2(NUM_PLANETS);
  localparam int DIFF_W = COORD_W + 1;
  localparam int SQ_W = 2 * DIFF_W;
  localparam int ACC_W = SQ_W + 1;
  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic [SIZE_W-1:0] size_t;
  typedef logic [IDX_W-1:0] plan_idx_t;
  typedef enum logic [2:0] {IDLE, FETCH, SQX, SQY, SQR, DONE} scan_state_t;
  localparam plan_idx_t NO_PLANET = '1;
  localparam plan_idx_t LAST_PLANET = plan_idx_t'(NUM_PLANETS - 1);
endpackage

// File: rtl/capture_scan_ctrl_if.sv
// capture_scan_ctrl_if: scan request, vessel, planet table and result signals.
interface capture_scan_ctrl_if;
  import orbit_pkg::*;
  logic scan_start;
  coord_t vessel_x;
  coord_t vessel_y;
  size_t vessel_s;
  plan_idx_t plan_sel;
  coord_t plan_x;
  coord_t plan_y;
  size_t plan_s;
  logic busy;
  logic done;
  logic hit;
  plan_idx_t hit_idx;
  modport master (
    output scan_start, vessel_x, vessel_y, vessel_s, plan_x, plan_y, plan_s,
    input plan_sel, busy, done, hit, hit_idx
  );
  modport slave (
    input scan_start, vessel_x, vessel_y, vessel_s, plan_x, plan_y, plan_s,
    output plan_sel, busy, done, hit, hit_idx
  );
endinterface

// File: rtl/sq_unit.sv
// sq_unit: combinational signed squarer; the result is always non-negative.
module sq_unit
  import orbit_pkg::*;
(
  input  logic signed [DIFF_W-1:0] a_i,
  output logic [SQ_W-1:0] sq_o
);
  logic signed [SQ_W-1:0] a_w;
  assign a_w = SQ_W'(a_i);
  assign sq_o = $unsigned(a_w * a_w);
endmodule

// File: rtl/capture_scan_ctrl.sv
// capture_scan_ctrl: walks the planet table through one shared squarer and
// reports the lowest-index planet whose disc overlaps the vessel disc.
module capture_scan_ctrl
  import orbit_pkg::*;
(
  input logic frame_clk,
  input logic Reset,
  capture_scan_ctrl_if.slave bus
);
  scan_state_t state_q;
  logic busy_q, done_q, hit_q;
  plan_idx_t hit_idx_q, sel_q;
  coord_t vx_q, vy_q, px_q, py_q;
  size_t vs_q, ps_q;
  logic [ACC_W-1:0] acc_q;
  logic signed [DIFF_W-1:0] dx, dy, op;
  logic [SQ_W-1:0] sq;
  assign dx = DIFF_W'(px_q) - DIFF_W'(vx_q);
  assign dy = DIFF_W'(py_q) - DIFF_W'(vy_q);
  // SQR reuses the squarer for the radius sum, zero-extended into the signed operand
  always_comb begin
    op = state_q == SQX ? dx : state_q == SQY ? dy : DIFF_W'({1'b0, ps_q} + {1'b0, vs_q});
  end
  sq_unit u_sq (.a_i(op), .sq_o(sq));
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hit_q <= 1'b0;
      hit_idx_q <= NO_PLANET;
      sel_q <= '0;
      vx_q <= '0;
      vy_q <= '0;
      vs_q <= '0;
      px_q <= '0;
      py_q <= '0;
      ps_q <= '0;
      acc_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.scan_start) begin
          vx_q <= bus.vessel_x;
          vy_q <= bus.vessel_y;
          vs_q <= bus.vessel_s;
          hit_q <= 1'b0;
          hit_idx_q <= NO_PLANET;
          sel_q <= '0;
          busy_q <= 1'b1;
          state_q <= FETCH;
        end
        FETCH: begin
          px_q <= bus.plan_x;
          py_q <= bus.plan_y;
          ps_q <= bus.plan_s;
          state_q <= SQX;
        end
        SQX: begin
          acc_q <= ACC_W'(sq);
          state_q <= SQY;
        end
        SQY: begin
          acc_q <= acc_q + ACC_W'(sq);
          state_q <= SQR;
        end
        SQR: if (acc_q <= ACC_W'(sq) || sel_q == LAST_PLANET) begin
          hit_q <= acc_q <= ACC_W'(sq);
          hit_idx_q <= acc_q <= ACC_W'(sq) ? sel_q : NO_PLANET;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state_q <= DONE;
        end else begin
          sel_q <= sel_q + 1'b1;
          state_q <= FETCH;
        end
        DONE: begin
          done_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.plan_sel = sel_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hit = hit_q;
  assign bus.hit_idx = hit_idx_q;
endmodule

// File: tb/tb_capture_scan_ctrl.sv
// tb_capture_scan_ctrl: directed vectors for capture_scan_ctrl plus hand-written
// sequences for ignored starts, table changes after fetch and mid-scan reset.
module tb_capture_scan_ctrl;
  import orbit_pkg::*;
  logic frame_clk = 1'b0;
  logic Reset = 1'b1;
  int ncmp = 0;
  int nerr = 0;
  coord_t px [NUM_PLANETS];
  coord_t py [NUM_PLANETS];
  size_t ps [NUM_PLANETS];
  capture_scan_ctrl_if bus();
  capture_scan_ctrl dut (.frame_clk(frame_clk), .Reset(Reset), .bus(bus));
  always #5 frame_clk = ~frame_clk;
  assign bus.plan_x = px[bus.plan_sel];
  assign bus.plan_y = py[bus.plan_sel];
  assign bus.plan_s = ps[bus.plan_sel];
  typedef struct {
    int vx, vy, vs;
    int fx, fy, fs;
    int ai, ax, ay, as_;
    int bi, bx, by, bs;
    int ed, eh, ei;
  } vec_t;
  vec_t vecs [7];
  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic load(input vec_t v);
    bus.vessel_x = coord_t'(v.vx);
    bus.vessel_y = coord_t'(v.vy);
    bus.vessel_s = size_t'(v.vs);
    for (int i = 0; i < NUM_PLANETS; i++) begin
      px[i] = coord_t'(i == v.ai ? v.ax : i == v.bi ? v.bx : v.fx);
      py[i] = coord_t'(i == v.ai ? v.ay : i == v.bi ? v.by : v.fy);
      ps[i] = size_t'(i == v.ai ? v.as_ : i == v.bi ? v.bs : v.fs);
    end
  endtask
  task automatic run_scan(output int dc, output int bc);
    dc = -1;
    bc = 0;
    @(negedge frame_clk);
    bus.scan_start = 1'b1;
    for (int c = 1; c <= 60 && dc < 0; c++) begin
      @(negedge frame_clk);
      if (c == 1) bus.scan_start = 1'b0;
      if (bus.busy) bc++;
      if (bus.done) dc = c;
    end
  endtask
  initial begin
    int dc, bc, ndone, first_dc, second_dc;
    vecs[0] = '{0, 0, 4, 2000, 2000, 1, 3, 10, 0, 6, -1, 0, 0, 0, 17, 1, 3};
    vecs[1] = '{0, 0, 1, 500, 500, 1, -1, 0, 0, 0, -1, 0, 0, 0, 33, 0, 7};
    vecs[2] = '{0, 0, 4, 2000, 2000, 1, 2, 3, 4, 1, 5, 0, 0, 1, 13, 1, 2};
    vecs[3] = '{-100, -50, 2, 2000, 2000, 1, 0, -103, -54, 3, -1, 0, 0, 0, 5, 1, 0};
    vecs[4] = '{0, 0, 4, 2000, 2000, 1, 6, 10, 1, 6, -1, 0, 0, 0, 33, 0, 7};
    vecs[5] = '{0, 0, 5, 2000, 2000, 1, 7, -6, -8, 5, -1, 0, 0, 0, 33, 1, 7};
    vecs[6] = '{2047, 2047, 255, -2048, -2048, 255, -1, 0, 0, 0, -1, 0, 0, 0, 33, 0, 7};
    bus.scan_start = 1'b0;
    load(vecs[1]);
    repeat (2) @(negedge frame_clk);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset hit", int'(bus.hit), 0);
    chk("reset hit_idx", int'(bus.hit_idx), 7);
    chk("reset plan_sel", int'(bus.plan_sel), 0);
    Reset = 1'b0;
    for (int v = 0; v < 7; v++) begin
      load(vecs[v]);
      run_scan(dc, bc);
      chk($sformatf("v%0d done cycle", v), dc, vecs[v].ed);
      chk($sformatf("v%0d busy cycles", v), bc, vecs[v].ed - 1);
      chk($sformatf("v%0d hit", v), int'(bus.hit), vecs[v].eh);
      chk($sformatf("v%0d hit_idx", v), int'(bus.hit_idx), vecs[v].ei);
      @(negedge frame_clk);
      chk($sformatf("v%0d done pulse width", v), int'(bus.done), 0);
      chk($sformatf("v%0d hit held", v), int'(bus.hit), vecs[v].eh);
      chk($sformatf("v%0d hit_idx held", v), int'(bus.hit_idx), vecs[v].ei);
    end
    // Starts during the scan and in the DONE cycle are dropped; cycle 34 is accepted
    load(vecs[1]);
    ndone = 0;
    first_dc = -1;
    second_dc = -1;
    @(negedge frame_clk);
    bus.scan_start = 1'b1;
    for (int c = 1; c <= 75; c++) begin
      @(negedge frame_clk);
      if (bus.done) begin
        ndone++;
        if (first_dc < 0) first_dc = c; else second_dc = c;
      end
      if (c == 34) chk("ignored start in DONE busy", int'(bus.busy), 0);
      if (c == 35) chk("start at 34 accepted busy", int'(bus.busy), 1);
      bus.scan_start = c == 3 || c == 17 || c == 33 || c == 34;
    end
    chk("handshake done count", ndone, 2);
    chk("handshake first done", first_dc, 33);
    chk("handshake second done", second_dc, 67);
    // Table changes after FETCH must not affect the planet being checked
    load(vecs[1]);
    px[0] = 12'sd10;
    py[0] = 12'sd0;
    ps[0] = 8'd6;
    bus.vessel_s = 8'd4;
    dc = -1;
    @(negedge frame_clk);
    bus.scan_start = 1'b1;
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      @(negedge frame_clk);
      bus.scan_start = 1'b0;
      if (c == 2) px[0] = 12'sd1500;
      if (bus.done) dc = c;
    end
    chk("fetch snapshot done", dc, 5);
    chk("fetch snapshot hit", int'(bus.hit), 1);
    chk("fetch snapshot hit_idx", int'(bus.hit_idx), 0);
    // Reset in the middle of a scan aborts it with no done pulse
    load(vecs[1]);
    ndone = 0;
    @(negedge frame_clk);
    bus.scan_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge frame_clk);
      bus.scan_start = 1'b0;
    end
    chk("pre-reset plan_sel", int'(bus.plan_sel), 2);
    Reset = 1'b1;
    #1;
    chk("mid reset busy", int'(bus.busy), 0);
    chk("mid reset plan_sel", int'(bus.plan_sel), 0);
    chk("mid reset hit_idx", int'(bus.hit_idx), 7);
    @(negedge frame_clk);
    Reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge frame_clk);
      if (bus.done || bus.busy) ndone++;
    end
    chk("no activity after reset", ndone, 0);
    load(vecs[0]);
    run_scan(dc, bc);
    chk("post-reset done cycle", dc, 17);
    chk("post-reset hit_idx", int'(bus.hit_idx), 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
